// File: rtl/vmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : vmem_responder
// Purpose  : Memory-side responder for the single-cycle processor memory
//            interface. Combinational reads, edge-committed writes, a host
//            backdoor with req/ack handshake, saturating access counters and
//            a sticky protocol-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module vmem_responder #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int CNT_W = 16,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_w_en,
  input  logic [AW-1:0]    mem_w_addr,
  input  logic [DW-1:0]    mem_w_data,
  input  logic             mem_r_en,
  input  logic [AW-1:0]    mem_r_addr,
  output logic [DW-1:0]    mem_r_data,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [DW-1:0]    host_wdata,
  output logic             host_ack,
  output logic [DW-1:0]    host_rdata,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  input  logic             cnt_clr,
  output logic             proto_err
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [DW-1:0] mem [DEPTH];
  state_t        state;
  logic          host_exec;

  // Read port is a plain mux; a same-edge write is not forwarded.
  assign mem_r_data = mem[mem_r_addr];

  // The host op runs only on an edge free of processor writes, so the two
  // writers can never collide on the same edge.
  assign host_exec = !mem_w_en &&
                     (((state == S_IDLE) && host_req) || (state == S_WAIT));

  // Storage array: processor write first, otherwise an executing host write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VAL;
    end else if (mem_w_en) begin
      mem[mem_w_addr] <= mem_w_data;
    end else if (host_exec && host_we) begin
      mem[host_addr] <= host_wdata;
    end
  end

  // Host handshake FSM with registered ack and read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_ack <= 1'b0;
      case (state)
        S_IDLE, S_WAIT: begin
          if (host_exec) begin
            state    <= S_RESP;
            host_ack <= 1'b1;
            if (!host_we) host_rdata <= mem[host_addr];
          end else if (host_req || (state == S_WAIT)) begin
            state <= S_WAIT;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Saturating access counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (cnt_clr) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (mem_r_en && (rd_cnt != CNT_MAX)) rd_cnt <= rd_cnt + 1'b1;
      if (mem_w_en && (wr_cnt != CNT_MAX)) wr_cnt <= wr_cnt + 1'b1;
    end
  end

  // Sticky flag for simultaneous processor read and write enables.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      proto_err <= 1'b0;
    else if (mem_w_en && mem_r_en) proto_err <= 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_vmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vmem_responder
// Purpose  : Directed, table-driven self-checking bench for vmem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [7:0]  mem_w_addr = '0;
  logic [7:0]  mem_w_data = '0;
  logic        mem_r_en = 1'b0;
  logic [7:0]  mem_r_addr = '0;
  logic [7:0]  mem_r_data;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic        cnt_clr = 1'b0;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  vmem_responder #(.AW(8), .DW(8), .CNT_W(16), .INIT_VAL(8'h00)) dut (
    .clk(clk), .rst(rst),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .cnt_clr(cnt_clr), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w_en;
    logic [7:0]  w_addr;
    logic [7:0]  w_data;
    logic        r_en;
    logic [7:0]  r_addr;
    logic [7:0]  exp_rdata;
    logic [15:0] exp_wr;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expected counter values are those before the vector's own edge.
    vecs[0] = '{1'b1, 8'h10, 8'h5A, 1'b0, 8'h10, 8'h00, 16'd0, 16'd0};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h5A, 16'd1, 16'd0};
    vecs[2] = '{1'b1, 8'h10, 8'h77, 1'b0, 8'h10, 8'h5A, 16'd1, 16'd1};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h77, 16'd2, 16'd1};
    vecs[4] = '{1'b1, 8'h11, 8'hA5, 1'b0, 8'h11, 8'h00, 16'd2, 16'd2};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h11, 8'hA5, 16'd3, 16'd2};
    vecs[6] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h77, 16'd3, 16'd2};
    vecs[7] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 16'd3, 16'd3};

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_host_ack", {31'd0, host_ack}, 0);
    chk("rst_host_rdata", {24'd0, host_rdata}, 0);
    chk("rst_rd_cnt", {16'd0, rd_cnt}, 0);
    chk("rst_wr_cnt", {16'd0, wr_cnt}, 0);
    chk("rst_proto_err", {31'd0, proto_err}, 0);
    for (int a = 0; a < 256; a++) begin
      mem_r_addr = a[7:0];
      #0.1;
      chk("rst_mem_init", {24'd0, mem_r_data}, 0);
    end
    tick();

    // ---------------- processor vector table ----------------
    for (int i = 0; i < 8; i++) begin
      mem_w_en   = vecs[i].w_en;
      mem_w_addr = vecs[i].w_addr;
      mem_w_data = vecs[i].w_data;
      mem_r_en   = vecs[i].r_en;
      mem_r_addr = vecs[i].r_addr;
      #2;
      chk($sformatf("vec%0d_rdata", i), {24'd0, mem_r_data}, {24'd0, vecs[i].exp_rdata});
      chk($sformatf("vec%0d_wr_cnt", i), {16'd0, wr_cnt}, {16'd0, vecs[i].exp_wr});
      chk($sformatf("vec%0d_rd_cnt", i), {16'd0, rd_cnt}, {16'd0, vecs[i].exp_rd});
      chk($sformatf("vec%0d_proto", i), {31'd0, proto_err}, 0);
      tick();
    end
    mem_w_en = 1'b0;
    mem_r_en = 1'b0;

    // ---------------- host write 0xC3 -> 0x20 ----------------
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'hC3;
    #1;
    chk("hw_ack_c0", {31'd0, host_ack}, 0);
    tick();
    chk("hw_ack_c1", {31'd0, host_ack}, 1);
    host_req = 1'b0;
    tick();
    chk("hw_ack_c2", {31'd0, host_ack}, 0);

    // ---------------- host read 0x20 ----------------
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    mem_r_addr = 8'h20;
    #1;
    chk("hr_ack_c0", {31'd0, host_ack}, 0);
    chk("hr_proc_read", {24'd0, mem_r_data}, 32'hC3);
    tick();
    chk("hr_ack_c1", {31'd0, host_ack}, 1);
    chk("hr_rdata", {24'd0, host_rdata}, 32'hC3);
    host_req = 1'b0;
    tick();
    chk("hr_ack_c2", {31'd0, host_ack}, 0);
    chk("hr_rdata_hold", {24'd0, host_rdata}, 32'hC3);

    // ---------------- arbitration: processor write wins for 3 cycles -----
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h11;
    mem_w_en = 1'b1; mem_w_addr = 8'h30; mem_w_data = 8'h22;
    mem_r_addr = 8'h30;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("arb_ack_c%0d", c), {31'd0, host_ack}, 0);
      tick();
    end
    mem_w_en = 1'b0;
    #1;
    chk("arb_ack_c3", {31'd0, host_ack}, 0);
    chk("arb_mem_proc", {24'd0, mem_r_data}, 32'h22);
    tick();
    chk("arb_ack_c4", {31'd0, host_ack}, 1);
    chk("arb_mem_final", {24'd0, mem_r_data}, 32'h11);
    host_req = 1'b0;
    tick();
    chk("arb_ack_c5", {31'd0, host_ack}, 0);
    chk("arb_mem_keep", {24'd0, mem_r_data}, 32'h11);

    // ---------------- counter saturation ----------------
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #1;
    chk("cnt_clr_rd", {16'd0, rd_cnt}, 0);
    mem_r_en = 1'b1;
    repeat (16'hFFFE) tick();
    mem_r_en = 1'b0;
    #1;
    chk("cnt_fffe", {16'd0, rd_cnt}, 32'hFFFE);
    mem_r_en = 1'b1;
    repeat (3) tick();
    mem_r_en = 1'b0;
    #1;
    chk("cnt_sat", {16'd0, rd_cnt}, 32'hFFFF);
    mem_r_en = 1'b1; cnt_clr = 1'b1;
    tick();
    mem_r_en = 1'b0; cnt_clr = 1'b0;
    #1;
    chk("cnt_clr_prio_rd", {16'd0, rd_cnt}, 0);
    chk("cnt_clr_prio_wr", {16'd0, wr_cnt}, 0);

    // ---------------- protocol error ----------------
    mem_w_en = 1'b1; mem_w_addr = 8'h40; mem_w_data = 8'h99;
    mem_r_en = 1'b1; mem_r_addr = 8'h40;
    #1;
    chk("pe_before", {31'd0, proto_err}, 0);
    chk("pe_old_data", {24'd0, mem_r_data}, 0);
    tick();
    mem_w_en = 1'b0; mem_r_en = 1'b0;
    #1;
    chk("pe_set", {31'd0, proto_err}, 1);
    chk("pe_write_done", {24'd0, mem_r_data}, 32'h99);
    chk("pe_rd_cnt", {16'd0, rd_cnt}, 1);
    chk("pe_wr_cnt", {16'd0, wr_cnt}, 1);
    repeat (3) tick();
    chk("pe_sticky", {31'd0, proto_err}, 1);

    // ---------------- reset while in WAIT ----------------
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h60; host_wdata = 8'h44;
    mem_w_en = 1'b1; mem_w_addr = 8'h50; mem_w_data = 8'h33;
    tick();
    tick();
    chk("rw_ack_wait", {31'd0, host_ack}, 0);
    mem_r_addr = 8'h50;
    #1;
    chk("rw_pre_mem50", {24'd0, mem_r_data}, 32'h33);
    rst = 1'b0;
    #1;
    chk("rw_ack_rst", {31'd0, host_ack}, 0);
    chk("rw_proto_rst", {31'd0, proto_err}, 0);
    chk("rw_mem50_rst", {24'd0, mem_r_data}, 0);
    mem_r_addr = 8'h30;
    #1;
    chk("rw_mem30_rst", {24'd0, mem_r_data}, 0);
    host_req = 1'b0; mem_w_en = 1'b0;
    #1;
    rst = 1'b1;
    mem_r_addr = 8'h60;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("rw_no_ack%0d", c), {31'd0, host_ack}, 0);
    end
    chk("rw_mem60", {24'd0, mem_r_data}, 0);
    chk("rw_wr_cnt", {16'd0, wr_cnt}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
